uop_sequencer: RTL



---
 rtl/uop_sequencer_pkg.sv | 25 ++
 rtl/uop_bundle_fifo.sv | 49 ++++
 rtl/uop_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uop_sequencer_pkg.sv
// Shared types for the uop sequencer slice: ALU sub-instruction, cracked bundle, issue FSM states.
package uop_sequencer_pkg;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [3:0]  dst;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [15:0] imm;
    } alu_inp_t;

    localparam int unsigned MAX_SUB_UOPS = 6;

    // Slot 0 sits at the MSB end, matching get_block ordering.
    typedef struct packed {
        logic [2:0]         cnt;
        alu_inp_t [0:5]     slot;
    } uop_bundle_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } issue_state_e;

endpackage

// File: rtl/uop_bundle_fifo.sv
// Bundle FIFO for uop_sequencer: storage, extra-MSB pointers, full/empty/one-entry flags.
module uop_bundle_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         one
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, rd_q;
    logic [AW:0]  count;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign count   = wr_q - rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign one     = (count == (AW+1)'(1));
    assign rdata   = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uop_sequencer.sv
// Issues cracked x86 bundles to the ALU one sub-instruction per cycle over valid/ready.
// Optional UOP_SEQ_STATS_EN adds saturating bundle/uop/stall counters.
module uop_sequencer
    import uop_sequencer_pkg::*;
#(
    parameter int unsigned UOP_W    = $bits(alu_inp_t),
    parameter int unsigned MAX_UOPS = MAX_SUB_UOPS,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_cnt,
    input  logic [UOP_W*MAX_UOPS-1:0] in_bits,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [UOP_W-1:0]          out_uop,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      err_cnt
`ifdef UOP_SEQ_STATS_EN
    ,
    output logic [31:0]               stat_bundles,
    output logic [31:0]               stat_uops,
    output logic [31:0]               stat_stall
`endif
);
    localparam int unsigned DW      = UOP_W * MAX_UOPS;
    localparam int unsigned EW      = DW + 3;
    localparam logic [2:0]  MAX_CNT = 3'(MAX_UOPS);

    issue_state_e    state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            err_q;
    logic [EW-1:0]   head;
    logic [2:0]      head_cnt;
    logic [DW-1:0]   head_bits;
    logic [UOP_W-1:0] slot_sel;
    logic            fifo_full, fifo_empty, fifo_one;
    logic            accept, push, fire, pop;

    assign in_ready  = !fifo_full && !flush;
    assign accept    = in_valid && in_ready;
    assign push      = accept && (in_cnt != 3'd0) && (in_cnt <= MAX_CNT);
    assign out_valid = (state_q == ISSUE);
    assign fire      = out_valid && out_ready;
    assign pop       = fire && out_last;
    assign head_cnt  = head[EW-1 -: 3];
    assign head_bits = head[DW-1:0];

    uop_bundle_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (flush),
        .push  (push),
        .wdata ({in_cnt, in_bits}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .one   (fifo_one)
    );

    always_comb begin
        slot_sel = '0;
        for (int unsigned i = 0; i < MAX_UOPS; i++) begin
            if (idx_q == 3'(i)) slot_sel = head_bits[(MAX_UOPS-i)*UOP_W-1 -: UOP_W];
        end
    end

    // Outputs are forced to zero when idle so nothing leaks from stale FIFO storage.
    assign out_uop   = out_valid ? slot_sel : '0;
    assign out_first = out_valid && (idx_q == 3'd0);
    assign out_last  = out_valid && (idx_q == head_cnt - 3'd1);
    assign err_cnt   = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (push || !fifo_empty) state_d = ISSUE;
                ISSUE: begin
                    if (fire) begin
                        if (out_last) begin
                            idx_d = '0;
                            if (fifo_one && !push) state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept && (in_cnt > MAX_CNT)) err_q <= 1'b1;
        end
    end

`ifdef UOP_SEQ_STATS_EN
    logic [31:0] bundles_q, uops_q, stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bundles_q <= '0;
            uops_q    <= '0;
            stall_q   <= '0;
        end else begin
            if (push && (bundles_q != '1))                     bundles_q <= bundles_q + 32'd1;
            if (fire && (uops_q != '1))                        uops_q    <= uops_q + 32'd1;
            if (out_valid && !out_ready && (stall_q != '1))    stall_q   <= stall_q + 32'd1;
        end
    end

    assign stat_bundles = bundles_q;
    assign stat_uops    = uops_q;
    assign stat_stall   = stall_q;
`endif

endmodule
